// File: rtl/mul_controller.sv
// mul_controller: Moore FSM sequencing a shift-free add-accumulate multiplier datapath.
module mul_controller #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] b_op,
  input  logic         abort,
  input  logic         eqz,
  output logic         loadA,
  output logic         loadB,
  output logic         decB,
  output logic         loadF,
  output logic         clear,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DONE} state_t;
  state_t state, nxt;
  logic [W-1:0] cnt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = abort ? IDLE : (cnt == '0 ? DONE : ACCUM);
      ACCUM:   nxt = abort ? IDLE : (cnt == W'(1) ? DONE : ACCUM);
      default: nxt = IDLE;
    endcase
  end
  // eqz must track the datapath B register, which lags cnt by one (it holds cnt-1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        cnt <= b_op;
        err <= 1'b0;
      end else if (state == ACCUM) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (eqz ? cnt > W'(1) : cnt == W'(1)) err <= 1'b1;
      end
    end
  end
  assign loadA = state == LOAD;
  assign loadB = state == LOAD;
  assign clear = state == LOAD;
  assign decB  = state == ACCUM;
  assign done  = state == DONE;
  assign loadF = state == DONE;
  assign busy  = state != IDLE;
endmodule

// File: tb/tb_mul_controller.sv
// tb_mul_controller: directed stimulus against a timeline model of the multiplier controller.
module tb_mul_controller;
  localparam int W = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, force0 = 1'b0;
  logic [W-1:0] b_op = '0;
  logic eqz, loadA, loadB, decB, loadF, clear, busy, done, err;
  logic [7:0] outs;
  logic [7:0] a_op = '0, a_reg = '0;
  logic [W-1:0] breg = '0;
  logic [15:0] prod = '0;
  int errors = 0, checks = 0, cyc = 0;
  bit m_act = 0, m_err = 0;
  int m_k = 0, m_b = 0, mp = 0, rem = 0, cp = 0;
  always #5 clk = ~clk;
  mul_controller #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .b_op(b_op), .abort(abort), .eqz(eqz),
    .loadA(loadA), .loadB(loadB), .decB(decB), .loadF(loadF), .clear(clear),
    .busy(busy), .done(done), .err(err)
  );
  assign outs = {busy, loadA, loadB, clear, decB, done, loadF, err};
  // bench-side datapath: A register, B register holding B-1, accumulating product
  assign eqz = !force0 && breg == '0;
  always @(posedge clk) begin
    if (loadA) a_reg <= a_op;
    if (loadB) breg <= b_op - 1'b1;
    else if (decB) breg <= breg - 1'b1;
    prod <= decB ? prod + {8'd0, a_reg} : 16'd0;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // phase of cycle c from the accept cycle m_k: 0 idle, 1 load, 2 accum, 3 done
  function automatic int phase(input int c);
    if (!m_act) return 0;
    if (c - m_k == 1) return 1;
    if (c - m_k <= 1 + m_b) return 2;
    return 3;
  endfunction
  always @(posedge clk) begin
    if (rst_n) begin
      mp = phase(cyc);
      if (mp == 0 && start) begin
        m_act = 1; m_k = cyc; m_b = int'(b_op); m_err = 0;
      end else if (mp == 2) begin
        rem = m_b + m_k + 2 - cyc;
        if (eqz ? rem > 1 : rem == 1) m_err = 1;
      end
      if (((mp == 1 || mp == 2) && abort) || mp == 3) m_act = 0;
    end
    cyc++;
  end
  always @(negedge rst_n) begin
    m_act = 0;
    m_err = 0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      cp = phase(cyc);
      chk("outputs", int'(outs), int'({cp != 0, cp == 1, cp == 1, cp == 1, cp == 2, cp == 3, cp == 3, m_err}));
    end
  end
  task automatic start_op(input int b, input int a, output int lc);
    @(negedge clk);
    start = 1'b1; b_op = W'(b); a_op = 8'(a);
    @(negedge clk);
    start = 1'b0;
    lc = cyc;
  endtask
  task automatic finish_op(input int lc, input int eb, input int ep, input int eerr);
    int dc = 0;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (decB) dc++;
      if (done) begin
        seen = 1;
        chk("done_latency", cyc - lc, eb + 1);
        chk("product", int'(prod), ep);
        chk("err_at_done", int'(err), eerr);
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("decB_cycles", dc, eb);
  endtask
  initial begin
    int lc, ad, nl, last;
    #12 chk("reset_outputs", int'(outs), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    start_op(3, 5, lc); finish_op(lc, 3, 15, 0);
    start_op(0, 7, lc); finish_op(lc, 0, 0, 0);
    force0 = 1'b1;
    start_op(2, 3, lc); finish_op(lc, 2, 6, 1);
    force0 = 1'b0;
    repeat (2) begin @(negedge clk); chk("err_sticky", int'(err), 1); end
    start_op(1, 4, lc); chk("err_cleared", int'(err), 0); finish_op(lc, 1, 4, 0);
    start_op(3, 2, lc);
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    ad = 0;
    repeat (6) begin @(negedge clk); if (done || loadF) ad++; end
    chk("abort_no_done", ad, 0);
    start_op(3, 6, lc);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("async_reset", int'(outs), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    start_op(2, 9, lc); finish_op(lc, 2, 18, 0);
    @(negedge clk); b_op = W'(1); a_op = 8'd3; start = 1'b1;
    nl = 0; last = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (loadA) begin
        if (nl > 0) chk("b2b_period", cyc - last, 4);
        last = cyc;
        nl++;
      end
    end
    start = 1'b0;
    chk("b2b_loads", nl, 3);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
